// File: rtl/ula_seq_pkg.sv
// ula_seq_pkg: shared FSM encoding and byte width for the byte-serial ALU front end
//   ula_seq_state_t : IDLE (accepting), RUN (one byte per cycle), DONE (result held)
//   BYTE_W          : width of the wrapped ALU slice
package ula_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ula_seq_state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/ula_8bits.sv
// ula_8bits: combinational 74181-style ALU slice, active-high data, active-low carries
//   a, b   : operand bytes        s : function select    m : 1 logic, 0 arithmetic
//   c_in   : carry in (0 = carry) f : result             c_out : carry out (0 = carry)
//   a_eq_b : high when f is all ones
module ula_8bits
  import ula_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic [3:0]        s,
  input  logic              m,
  input  logic              c_in,
  output logic [BYTE_W-1:0] f,
  output logic              c_out,
  output logic              a_eq_b
);
  logic [BYTE_W-1:0] w_p, w_g;
  logic [BYTE_W:0]   w_sum;
  // Arithmetic is always w_p plus w_g; w_g is a subset of w_p, so their
  // bitwise XNOR is exactly the 74181 logic-mode output.
  assign w_p    = a | (b & {BYTE_W{s[0]}}) | (~b & {BYTE_W{s[1]}});
  assign w_g    = (a & ~b & {BYTE_W{s[2]}}) | (a & b & {BYTE_W{s[3]}});
  assign w_sum  = {1'b0, w_p} + {1'b0, w_g} + {{BYTE_W{1'b0}}, ~c_in};
  assign f      = m ? ~(w_p ^ w_g) : w_sum[BYTE_W-1:0];
  // Carry propagates regardless of mode so chained slices behave like real parts.
  assign c_out  = ~w_sum[BYTE_W];
  assign a_eq_b = &f;
endmodule

// File: rtl/ula_16bits_seq.sv
// ula_16bits_seq: byte-serial wide-operand front end driving one ula_8bits, LSB first
//   in_valid/in_ready   : operation handshake (a, b, s, m, c_in latched on accept)
//   out_valid/out_ready : result handshake (f, c_out, a_eq_b valid and stable in DONE)
//   busy                : high while bytes are being processed
module ula_16bits_seq
  import ula_seq_pkg::*;
#(
  parameter int N_BYTES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*N_BYTES-1:0] a,
  input  logic [BYTE_W*N_BYTES-1:0] b,
  input  logic [3:0]                s,
  input  logic                      m,
  input  logic                      c_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTE_W*N_BYTES-1:0] f,
  output logic                      c_out,
  output logic                      a_eq_b,
  output logic                      busy
);
  localparam int W  = BYTE_W * N_BYTES;
  localparam int IW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);
  ula_seq_state_t    r_state;
  logic [W-1:0]      r_a, r_b, r_f;
  logic [3:0]        r_s;
  logic              r_m, r_cy, r_eq;
  logic [IW-1:0]     r_idx;
  logic [BYTE_W-1:0] w_a, w_b, w_f;
  logic              w_c, w_eq;
  assign w_a = r_a[r_idx*BYTE_W +: BYTE_W];
  assign w_b = r_b[r_idx*BYTE_W +: BYTE_W];
  ula_8bits u_alu (
    .a      (w_a),
    .b      (w_b),
    .s      (r_s),
    .m      (r_m),
    .c_in   (r_cy),
    .f      (w_f),
    .c_out  (w_c),
    .a_eq_b (w_eq)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_f     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_cy    <= 1'b0;
      r_eq    <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_s     <= s;
          r_m     <= m;
          r_cy    <= c_in;
          r_eq    <= 1'b1;
          r_idx   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_f[r_idx*BYTE_W +: BYTE_W] <= w_f;
          r_cy <= w_c;
          r_eq <= r_eq & w_eq;
          // Hold the index on the last byte so it never wraps.
          if (r_idx == LAST) r_state <= DONE;
          else r_idx <= r_idx + 1'b1;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state == RUN;
  assign out_valid = r_state == DONE;
  assign f         = out_valid ? r_f : '0;
  assign c_out     = out_valid & r_cy;
  assign a_eq_b    = out_valid & r_eq;
endmodule
